// File: rtl/mem_lsu.sv
// Byte-serial load/store unit: one data-memory byte per ACCESS cycle, with wrap at 512.
// Optional LSU_MISALIGN_TRAP_EN rejects misaligned word/halfword accesses instead of splitting them.
module mem_lsu (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        DMWr,
    output logic [8:0]  addr,
    output logic [31:0] din,
    output logic [2:0]  DMType,
    input  logic [31:0] dout
);

    localparam logic [2:0] DM_WORD              = 3'd0;
    localparam logic [2:0] DM_HALFWORD          = 3'd1;
    localparam logic [2:0] DM_HALFWORD_UNSIGNED = 3'd2;
    localparam logic [2:0] DM_BYTE              = 3'd3;
    localparam logic [2:0] DM_BYTE_UNSIGNED     = 3'd4;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state;
    logic        we_q;
    logic [2:0]  type_q;
    logic [8:0]  addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  cnt;
    logic [31:0] asm_q;
    logic        err_q;
    logic        misalign;
    logic        in_access;
    logic        unused_bits;

    function automatic logic [1:0] last_idx(input logic [2:0] t);
        case (t)
            DM_WORD:                           return 2'd3;
            DM_HALFWORD, DM_HALFWORD_UNSIGNED: return 2'd1;
            default:                           return 2'd0;
        endcase
    endfunction

    function automatic logic type_ok(input logic we, input logic [2:0] t);
        case (t)
            DM_WORD, DM_HALFWORD, DM_BYTE:             return 1'b1;
            DM_HALFWORD_UNSIGNED, DM_BYTE_UNSIGNED:    return !we;
            default:                                   return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] t, input logic [31:0] v);
        case (t)
            DM_HALFWORD:          return {{16{v[15]}}, v[15:0]};
            DM_HALFWORD_UNSIGNED: return {16'b0, v[15:0]};
            DM_BYTE:              return {{24{v[7]}}, v[7:0]};
            DM_BYTE_UNSIGNED:     return {24'b0, v[7:0]};
            default:              return v;
        endcase
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((req_type == DM_WORD) && (req_addr[1:0] != 2'b00)) ||
                      (((req_type == DM_HALFWORD) || (req_type == DM_HALFWORD_UNSIGNED)) && req_addr[0]);
`else
    assign misalign = 1'b0;
`endif

    // Address bits above the 512-byte window and the upper read lanes are don't-care.
    assign unused_bits = ^{req_addr[31:9], dout[31:8]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            type_q  <= DM_BYTE_UNSIGNED;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt     <= '0;
            asm_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        type_q  <= req_type;
                        addr_q  <= req_addr[8:0];
                        wdata_q <= req_wdata;
                        cnt     <= '0;
                        asm_q   <= '0;
                        if (type_ok(req_we, req_type) && !misalign) begin
                            err_q <= 1'b0;
                            state <= ACCESS;
                        end else begin
                            err_q <= 1'b1;
                            state <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    if (!we_q)
                        asm_q[{cnt, 3'b000} +: 8] <= dout[7:0];
                    if (cnt == last_idx(type_q))
                        state <= RESP;
                    else
                        cnt <= cnt + 2'd1;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory-side signals are decoded from registered state only, so reset clears them at once.
    assign in_access  = (state == ACCESS);
    assign req_ready  = (state == IDLE);
    assign DMWr       = in_access && we_q;
    assign addr       = in_access ? (addr_q + 9'(cnt)) : 9'd0;
    assign din        = in_access ? {24'b0, wdata_q[{cnt, 3'b000} +: 8]} : 32'd0;
    assign DMType     = (in_access && we_q) ? DM_BYTE : DM_BYTE_UNSIGNED;
    assign resp_valid = (state == RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && !err_q) ? extend(type_q, asm_q) : 32'd0;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: byte-array memory, reference model over a shadow image.
module tb_mem_lsu;

    localparam logic [2:0] DM_WORD              = 3'd0;
    localparam logic [2:0] DM_HALFWORD          = 3'd1;
    localparam logic [2:0] DM_HALFWORD_UNSIGNED = 3'd2;
    localparam logic [2:0] DM_BYTE              = 3'd3;
    localparam logic [2:0] DM_BYTE_UNSIGNED     = 3'd4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_type = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        DMWr;
    logic [8:0]  addr;
    logic [31:0] din;
    logic [2:0]  DMType;
    logic [31:0] dout;

    logic [7:0] mem    [0:511];
    logic [7:0] shadow [0:511];

    int cyc = 0;
    int wr_cnt = 0;
    int exp_wr = 0;
    int total = 0;
    int bad = 0;
    int last_acc = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    mem_lsu dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .DMWr(DMWr), .addr(addr), .din(din), .DMType(DMType), .dout(dout)
    );

    always #5 clk = ~clk;

    // Combinational-read data memory; upper lanes carry junk the unit must ignore.
    assign dout = {24'hA5C35A, mem[addr]};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (DMWr) begin
            mem[addr] <= din[7:0];
            wr_cnt    <= wr_cnt + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic int nbytes(input logic [2:0] t);
        if (t == DM_WORD) return 4;
        if (t == DM_HALFWORD || t == DM_HALFWORD_UNSIGNED) return 2;
        return 1;
    endfunction

    function automatic bit is_legal(input bit we, input logic [2:0] t, input logic [8:0] a);
        if (t > DM_BYTE_UNSIGNED) return 0;
        if (we && (t == DM_HALFWORD_UNSIGNED || t == DM_BYTE_UNSIGNED)) return 0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (t == DM_WORD && (a % 4) != 0) return 0;
        if ((t == DM_HALFWORD || t == DM_HALFWORD_UNSIGNED) && (a % 2) != 0) return 0;
`else
        if (a > 9'd511) return 0;
`endif
        return 1;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [8:0] a);
        logic [31:0] v = 32'd0;
        int n = nbytes(t);
        for (int i = 0; i < n; i++)
            v = v + (32'(shadow[(int'(a) + i) % 512]) << (8 * i));
        if (t == DM_HALFWORD && v >= 32'h8000) v = v + 32'hFFFF0000;
        if (t == DM_BYTE && v >= 32'h80) v = v + 32'hFFFFFF00;
        return v;
    endfunction

    task automatic issue(input bit we, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] wd, input bit model);
        exp_t e;
        bit   legal;
        int   waited = 0;
        req_we = we; req_type = t; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        while (!req_ready && waited < 40) begin
            @(posedge clk); #2;
            waited++;
        end
        if (!req_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout actual=ready_low required=ready_high");
            req_valid = 1'b0;
            return;
        end
        last_acc = cyc;
        if (model) begin
            legal   = is_legal(we, t, a[8:0]);
            e.acc   = cyc;
            e.err   = !legal;
            e.lat   = legal ? nbytes(t) + 1 : 1;
            e.rdata = (legal && !we) ? ref_load(t, a[8:0]) : 32'd0;
            if (legal && we) begin
                for (int i = 0; i < nbytes(t); i++)
                    shadow[(int'(a[8:0]) + i) % 512] = wd[8*i +: 8];
                exp_wr += nbytes(t);
            end
            sbq.push_back(e);
        end
        @(posedge clk); #2;
    endtask

    task automatic wait_done();
        int k = 0;
        req_valid = 1'b0;
        while (sbq.size() != 0 && k < 60) begin
            @(posedge clk); #2;
            k++;
        end
        if (sbq.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout actual=%0d required=0", sbq.size());
            sbq.delete();
        end
        @(posedge clk); #2;
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (DMWr) chk("store_dmtype", 32'(DMType), 32'(DM_BYTE));
            if (resp_valid) begin
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_resp actual=resp_valid required=none");
                end else begin
                    mon_e = sbq.pop_front();
                    chk("resp_rdata", resp_rdata, mon_e.rdata);
                    chk("resp_err", 32'(resp_err), 32'(mon_e.err));
                    chk("resp_latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
                end
            end
        end
    end

    initial begin
        logic [31:0] v;
        logic [7:0]  exp_b [0:3];
        int          a1, a2, wr_snap, nm;

        for (int i = 0; i < 512; i++) begin
            v = $urandom;
            mem[i] <= v[7:0];
            shadow[i] = v[7:0];
        end

        repeat (3) @(posedge clk);
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_dmwr", 32'(DMWr), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_din", din, 32'd0);
        chk("rst_dmtype", 32'(DMType), 32'(DM_BYTE_UNSIGNED));
        rstn = 1'b1;
        @(posedge clk); #2;

        // Word store then word load
        issue(1, DM_WORD, 32'h010, 32'hDEADBEEF, 1);
        issue(0, DM_WORD, 32'h010, 32'h0, 1);
        wait_done();
        exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
        for (int i = 0; i < 4; i++) chk("word_store_byte", 32'(mem[16 + i]), 32'(exp_b[i]));

        // Sign/zero extension of 0x80,0xFF
        issue(1, DM_BYTE, 32'h020, 32'h00000080, 1);
        issue(1, DM_BYTE, 32'h021, 32'h000000FF, 1);
        issue(0, DM_HALFWORD, 32'h020, 32'h0, 1);
        issue(0, DM_HALFWORD_UNSIGNED, 32'h020, 32'h0, 1);
        issue(0, DM_BYTE, 32'h020, 32'h0, 1);
        issue(0, DM_BYTE_UNSIGNED, 32'h020, 32'h0, 1);
        wait_done();
        chk("ext_src_0", 32'(mem[32]), 32'h80);
        chk("ext_src_1", 32'(mem[33]), 32'hFF);

        // Wrapping word store at the top of the window
        issue(1, DM_WORD, 32'h1FE, 32'h11223344, 1);
        wait_done();
`ifndef LSU_MISALIGN_TRAP_EN
        chk("wrap_1fe", 32'(mem[510]), 32'h44);
        chk("wrap_1ff", 32'(mem[511]), 32'h33);
        chk("wrap_000", 32'(mem[0]), 32'h22);
        chk("wrap_001", 32'(mem[1]), 32'h11);
`else
        chk("trap_1fe", 32'(mem[510]), 32'(shadow[510]));
        chk("trap_000", 32'(mem[0]), 32'(shadow[0]));
`endif

        // Illegal requests leave memory untouched
        wr_snap = wr_cnt;
        issue(1, DM_BYTE_UNSIGNED, 32'h030, 32'h5A5A5A5A, 1);
        issue(0, 3'b111, 32'h030, 32'h0, 1);
        wait_done();
        chk("illegal_no_write", 32'(wr_cnt), 32'(wr_snap));

        // Asynchronous reset during the second byte of a word store
        issue(1, DM_WORD, 32'h040, 32'hCAFEBABE, 0);
        @(posedge clk); #2;
        chk("pre_reset_dmwr", 32'(DMWr), 32'd1);
        chk("pre_reset_addr", 32'(addr), 32'h041);
        rstn = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("async_dmwr", 32'(DMWr), 32'd0);
        chk("async_addr", 32'(addr), 32'd0);
        chk("async_din", din, 32'd0);
        chk("async_req_ready", 32'(req_ready), 32'd1);
        chk("async_resp_valid", 32'(resp_valid), 32'd0);
        #1;
        rstn = 1'b1;
        shadow[64] = 8'hBE;
        exp_wr += 1;
        repeat (6) @(posedge clk);
        #2;
        chk("reset_byte0", 32'(mem[64]), 32'hBE);
        chk("reset_byte1", 32'(mem[65]), 32'(shadow[65]));

        // Held req_valid: back-to-back byte loads
        issue(0, DM_BYTE, 32'h050, 32'h0, 1);
        a1 = last_acc;
        issue(0, DM_BYTE_UNSIGNED, 32'h051, 32'h0, 1);
        a2 = last_acc;
        wait_done();
        chk("b2b_spacing", 32'(a2 - a1), 32'd3);

        // Random mix
        for (int n = 0; n < 80; n++) begin
            issue(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom, 1);
            if ($urandom_range(0, 1) == 1) begin
                req_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #2;
            end
        end
        wait_done();

        nm = 0;
        for (int i = 0; i < 512; i++) if (mem[i] !== shadow[i]) nm++;
        chk("mem_image", 32'(nm), 32'd0);
        chk("write_count", 32'(wr_cnt), 32'(exp_wr));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rstn  input  1  reset, asynchronous, active-low.
REQ-003 req_valid  input  1  pipeline presents a load/store request.
REQ-004 req_ready  output  1  unit can accept a request; high only in IDLE.
REQ-005 req_we  input  1  1 = store, 0 = load.
REQ-006 req_type  input  3  access type, dm_word/dm_halfword/dm_byte/dm_halfword_unsigned/dm_byte_unsigned encodings from the shared control-encoding header.
REQ-007 req_addr  input  32  byte address; only bits [8:0] are used.
REQ-008 req_wdata  input  32  store data, LSB-aligned.
REQ-009 resp_valid  output  1  one-cycle pulse: request complete.
REQ-010 resp_rdata  output  32  load result, extended per type; 0 for stores and errors.
REQ-011 resp_err  output  1  qualified by resp_valid: request rejected, no memory effect.
REQ-012 DMWr  output  1  data-memory write enable.
REQ-013 addr  output  9  data-memory byte address.
REQ-014 din  output  32  data-memory write data.
REQ-015 DMType  output  3  data-memory access type; always dm_byte for stores, dm_byte_unsigned for loads.
REQ-016 dout  input  32  data-memory combinational read data.

Function
REQ-017 FSM states: IDLE, ACCESS, RESP.
- IDLE->ACCESS on req_valid&&req_ready with a legal request.
- IDLE->RESP on an illegal request.
- ACCESS->RESP after the last byte.
- RESP->IDLE unconditionally.
REQ-018 On acceptance, latch we, type, addr[8:0] and wdata, and clear the byte counter and the assembly register.
REQ-019 Byte count N: 4 for word, 2 for halfword and halfword_unsigned, 1 for byte and byte_unsigned.
REQ-020 In ACCESS cycle k (k=0..N-1):
- addr = (latched addr + k) mod 512; wrap 511->0 is required.
- DMWr = we; din = {24'b0, wdata byte k}.
REQ-021 Loads: at the end of ACCESS cycle k, store dout[7:0] into assembly byte k.
REQ-022 In RESP: resp_valid=1 and resp_rdata = assembly value.
- Signed types sign-extend from bit 15 (halfword) or bit 7 (byte).
- Unsigned types zero-extend.
REQ-023 Latency from acceptance to resp_valid: N+1 cycles for a legal request, 1 cycle for an illegal request.
REQ-024 Illegal requests:
- any unlisted type encoding;
- a store with either unsigned type.
Response: resp_err=1, resp_rdata=0, DMWr never asserted.
REQ-025 Outside ACCESS: DMWr=0, addr=0, din=0, DMType=dm_byte_unsigned.
REQ-026 DMWr and addr are decoded from registered state only; no combinational path from req_* to memory outputs.
REQ-027 req_valid while busy is ignored; the pipeline holds the request until req_ready.
REQ-028 A new request is accepted no earlier than the cycle after RESP; back-to-back throughput is N+2 cycles.

Reset
REQ-029 Asynchronous rstn low forces the following immediately, including mid-ACCESS:
- state=IDLE;
- req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0;
- DMWr=0, addr=0, din=0, DMType=dm_byte_unsigned.
An interrupted store leaves already-written bytes written and issues no response.

Configuration
REQ-030 Macro LSU_MISALIGN_TRAP_EN.
- Defined: a word with addr[1:0]!=0, or a halfword type with addr[0]!=0, is illegal per REQ-024.
- Undefined: misaligned accesses execute byte-serially with wrap per REQ-020.

Verification
REQ-031 Word store 0xDEADBEEF @0x010, then word load @0x010 -> bytes EF,BE,AD,DE at 0x010..0x013; resp_rdata=0xDEADBEEF, resp_valid 5 cycles after acceptance.
REQ-032 Bytes 0x80,0xFF at 0x020,0x021:
- dm_halfword load @0x020 -> 0xFFFFFF80;
- dm_halfword_unsigned -> 0x0000FF80;
- dm_byte -> 0xFFFFFF80;
- dm_byte_unsigned -> 0x00000080.
REQ-033 Word store 0x11223344 @0x1FE without LSU_MISALIGN_TRAP_EN -> writes 44@0x1FE, 33@0x1FF, 22@0x000, 11@0x001. With the macro defined -> resp_err=1 after 1 cycle and no DMWr.
REQ-034 Store with dm_byte_unsigned type, and a load with unlisted type 3'b111 -> resp_err=1, resp_rdata=0, DMWr stays 0.
REQ-035 Assert rstn low during the 2nd ACCESS cycle of a word store @0x040 -> DMWr drops without waiting for a clock edge; only 0x040 is modified; no resp_valid; req_ready=1.
REQ-036 req_valid held high continuously with two byte loads -> second acceptance exactly 3 cycles after the first; no request lost or duplicated.
